// File: rtl/capture_ctrl_if.sv
// capture_ctrl_if: shared RAM port of the three channel RAMs plus the readout stream handshake
interface capture_ctrl_if;
    logic       rclk;
    logic       en;
    logic       we;
    logic [8:0] addr;
    logic       dump_start;
    logic       dump_stall;
    logic       smp_vld;
    logic [8:0] smp_idx;

    modport master (
        output rclk, en, we, addr, smp_vld, smp_idx,
        input  dump_start, dump_stall
    );

    modport slave (
        input  rclk, en, we, addr, smp_vld, smp_idx,
        output dump_start, dump_stall
    );
endinterface

// File: rtl/capture_ctrl.sv
// capture_ctrl: pre/post-trigger ring-buffer capture sequencer with decimation and stallable readout
module capture_ctrl (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           trig1,
    input  logic           trig2,
    input  logic           trig_src,
    input  logic           trig_edge,
    input  logic [8:0]     trig_pos,
    input  logic [3:0]     dec,
    input  logic           arm,
    output logic           adc_clk,
    output logic [8:0]     trig_addr,
    output logic           busy,
    output logic           capture_done,
    capture_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE, DUMP} state_t;

    state_t      state, state_nx;
    logic        ph, sel_d, flag, pend;
    logic [1:0]  t1_s, t2_s;
    logic [14:0] dcnt, mask;
    logic [8:0]  wp, cnt, pend_idx, pre_n;
    logic [9:0]  i;
    logic        sel, edge_det, wslot, capturing, wr, rd, vld, start, dump_go;

    assign mask      = 15'((16'd1 << dec) - 16'd1);
    assign wslot     = ph && ((dcnt & mask) == '0);
    assign capturing = state == PRE || state == ARMED || state == POST;
    assign wr        = capturing && wslot;
    // i[9] marks that all 512 entries have been presented
    assign rd        = state == DUMP && ph && !bus.dump_stall && !i[9];
    assign vld       = ph && pend;
    assign start     = arm && (state == IDLE || state == DONE);
    assign dump_go   = state == DONE && !arm && bus.dump_start;
    assign pre_n     = 9'd511 - trig_pos;
    assign sel       = trig_src ? t2_s[1] : t1_s[1];
    assign edge_det  = trig_edge ? (sel && !sel_d) : (!sel && sel_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ph        <= 1'b0;
            t1_s      <= '0;
            t2_s      <= '0;
            sel_d     <= 1'b0;
            flag      <= 1'b0;
            dcnt      <= '0;
            wp        <= '0;
            cnt       <= '0;
            i         <= '0;
            pend      <= 1'b0;
            pend_idx  <= '0;
            trig_addr <= '0;
        end else begin
            state     <= state_nx;
            ph        <= ~ph;
            t1_s      <= {t1_s[0], trig1};
            t2_s      <= {t2_s[0], trig2};
            sel_d     <= sel;
            // edges only count while armed; a pending edge is spent on the next write slot
            flag      <= state == ARMED && !(wslot && flag) && (flag || edge_det);
            dcnt      <= start ? '0 : ph ? dcnt + 15'd1 : dcnt;
            wp        <= start ? '0 : wr ? wp + 9'd1 : wp;
            cnt       <= (start || state == ARMED) ? '0 : wr ? cnt + 9'd1 : cnt;
            trig_addr <= (state == ARMED && wr && flag) ? wp : trig_addr;
            i         <= dump_go ? '0 : rd ? i + 10'd1 : i;
            pend      <= rd || (pend && !ph);
            pend_idx  <= rd ? i[8:0] : pend_idx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = arm ? (trig_pos == 9'd511 ? ARMED : PRE) : IDLE;
            PRE:     state_nx = (wr && cnt == pre_n - 9'd1) ? ARMED : PRE;
            ARMED:   state_nx = (wr && flag) ? (trig_pos == 9'd0 ? DONE : POST) : ARMED;
            POST:    state_nx = (wr && cnt == trig_pos - 9'd1) ? DONE : POST;
            DONE:    state_nx = arm ? (trig_pos == 9'd511 ? ARMED : PRE) : bus.dump_start ? DUMP : DONE;
            DUMP:    state_nx = (vld && pend_idx == 9'd511) ? DONE : DUMP;
            default: state_nx = IDLE;
        endcase
    end

    assign adc_clk      = ph;
    assign bus.rclk     = ~ph;
    assign bus.en       = wr || rd;
    assign bus.we       = wr;
    assign bus.addr     = state == DUMP ? wp + i[8:0] : wp;
    assign bus.smp_vld  = vld;
    assign bus.smp_idx  = pend_idx;
    assign busy         = capturing || state == DUMP;
    assign capture_done = state == DONE;
endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed capture, trigger, decimation, dump and reset scenarios for capture_ctrl
module tb_capture_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       trig1 = 1'b0, trig2 = 1'b0, trig_src = 1'b0, trig_edge = 1'b1, arm = 1'b0;
    logic [8:0] trig_pos = '0;
    logic [3:0] dec = '0;
    logic       adc_clk, busy, capture_done;
    logic [8:0] trig_addr;
    int         n_chk = 0, n_fail = 0;
    int         tot_w = 0, last_wa = 0, tot_r = 0, tot_v = 0, rd_bad = 0, vld_bad = 0;
    int         w0 = 0, r0 = 0, v0 = 0, rd_base = 0;
    bit         mon_dump = 1'b0;

    capture_ctrl_if bus();

    capture_ctrl dut (
        .clk(clk), .rst_n(rst_n), .trig1(trig1), .trig2(trig2), .trig_src(trig_src),
        .trig_edge(trig_edge), .trig_pos(trig_pos), .dec(dec), .arm(arm),
        .adc_clk(adc_clk), .trig_addr(trig_addr), .busy(busy), .capture_done(capture_done),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            tot_w++;
            last_wa = int'(bus.addr);
        end
        if (mon_dump && bus.en === 1'b1 && bus.we === 1'b0) begin
            if (int'(bus.addr) != (rd_base + tot_r - r0) % 512) rd_bad++;
            tot_r++;
        end
        if (mon_dump && bus.smp_vld === 1'b1) begin
            if (int'(bus.smp_idx) != tot_v - v0) vld_bad++;
            tot_v++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_adc_clk", adc_clk, 1'b0);
        chk("rst_rclk", bus.rclk, 1'b1);
        chk("rst_en", bus.en, 1'b0);
        chk("rst_we", bus.we, 1'b0);
        chk("rst_addr", bus.addr, 0);
        chk("rst_trig_addr", trig_addr, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", capture_done, 1'b0);
        chk("rst_smp_vld", bus.smp_vld, 1'b0);
        chk("rst_smp_idx", bus.smp_idx, 0);
    endtask

    // arm lands in a ph=0 cycle so the first write slot follows the next edge
    task automatic arm_pulse(input bit with_dump);
        int k = 0;
        while (adc_clk !== 1'b0 && k < 4) begin
            tick();
            k++;
        end
        w0 = tot_w;
        arm = 1'b1;
        bus.dump_start = with_dump;
        tick();
        arm = 1'b0;
        bus.dump_start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (capture_done !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n, a0, a1, prev, k;
        bus.dump_start = 1'b0;
        bus.dump_stall = 1'b0;
        ticks(3);
        chk_reset();
        rst_n = 1'b1;
        ticks(2);

        trig_pos = 9'd100;
        arm_pulse(1'b0);
        chk("t1_busy_pre", busy, 1'b1);
        ticks(1199);
        chk("t1_busy_armed", busy, 1'b1);
        chk("t1_not_done", capture_done, 1'b0);
        trig1 = 1'b1;
        ticks(100);
        bus.dump_start = 1'b1;
        tick();
        bus.dump_start = 1'b0;
        wait_done(n);
        chk("t1_latency", n, 103);
        chk("t1_trig_addr", trig_addr, 89);
        chk("t1_writes", tot_w - w0, 702);
        chk("t1_last_waddr", last_wa, 189);
        chk("t1_busy_done", busy, 1'b0);

        rd_base = 190;
        r0 = tot_r;
        v0 = tot_v;
        mon_dump = 1'b1;
        bus.dump_start = 1'b1;
        tick();
        bus.dump_start = 1'b0;
        chk("dump_busy", busy, 1'b1);
        chk("dump_not_done", capture_done, 1'b0);
        ticks(300);
        bus.dump_stall = 1'b1;
        #1;
        a0 = int'(bus.addr);
        chk("stall_en", bus.en, 1'b0);
        ticks(5);
        a1 = int'(bus.addr);
        bus.dump_stall = 1'b0;
        chk("stall_addr_frozen", a1, a0);
        wait_done(n);
        mon_dump = 1'b0;
        chk("dump_back_to_done", capture_done, 1'b1);
        chk("dump_reads", tot_r - r0, 512);
        chk("dump_vld_pulses", tot_v - v0, 512);
        chk("dump_addr_seq_errs", rd_bad, 0);
        chk("dump_idx_seq_errs", vld_bad, 0);

        bus.dump_start = 1'b1;
        tick();
        bus.dump_start = 1'b0;
        ticks(100);
        chk("dump2_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_reset();
        tick();
        chk("dump_rst_hold_en", bus.en, 1'b0);
        rst_n = 1'b1;
        ticks(10);
        chk("dump_rst_idle_en", bus.en, 1'b0);
        chk("dump_rst_idle_busy", busy, 1'b0);

        trig1 = 1'b0;
        ticks(4);
        arm_pulse(1'b0);
        ticks(599);
        trig1 = 1'b1;
        ticks(100);
        trig1 = 1'b0;
        ticks(120);
        trig1 = 1'b1;
        ticks(80);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        wait_done(n);
        chk("t3_latency", n, 123);
        chk("t3_trig_addr", trig_addr, 411);
        chk("t3_writes", tot_w - w0, 512);
        chk("t3_last_waddr", last_wa, 511);

        trig_pos = 9'd511;
        trig1 = 1'b0;
        ticks(4);
        arm_pulse(1'b1);
        trig1 = 1'b1;
        wait_done(n);
        chk("t4_latency", n, 1027);
        chk("t4_trig_addr", trig_addr, 2);
        chk("t4_writes", tot_w - w0, 514);
        chk("t4_last_waddr", last_wa, 1);

        dec = 4'd3;
        trig_pos = 9'd100;
        trig1 = 1'b0;
        ticks(4);
        arm_pulse(1'b0);
        chk("dec_first_we", bus.we, 1'b1);
        prev = 1;
        k = 0;
        for (int c = 2; c <= 80; c++) begin
            tick();
            if (bus.we === 1'b1) begin
                chk("dec_gap", c - prev, 16);
                prev = c;
                k++;
            end
        end
        chk("dec_pulses", k, 4);
        dec = 4'd0;
        rst_n = 1'b0;
        #1;
        chk("dec_rst_busy", busy, 1'b0);
        tick();
        rst_n = 1'b1;
        ticks(2);

        trig_pos = 9'd511;
        trig1 = 1'b0;
        ticks(4);
        arm_pulse(1'b0);
        trig1 = 1'b1;
        ticks(99);
        chk("post_busy", busy, 1'b1);
        chk("post_not_done", capture_done, 1'b0);
        chk("post_trig_addr", trig_addr, 2);
        chk("post_writes", tot_w - w0, 50);
        rst_n = 1'b0;
        #1;
        chk_reset();
        tick();
        rst_n = 1'b1;
        ticks(2);

        trig_pos = 9'd0;
        trig_src = 1'b1;
        trig_edge = 1'b0;
        trig2 = 1'b1;
        trig1 = 1'b0;
        ticks(4);
        arm_pulse(1'b0);
        ticks(1025);
        trig1 = 1'b1;
        ticks(4);
        trig2 = 1'b0;
        wait_done(n);
        chk("t5_latency", n, 4);
        chk("t5_trig_addr", trig_addr, 4);
        chk("t5_writes", tot_w - w0, 517);
        chk("t5_last_waddr", last_wa, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 SHALL have no parameters; buffer depth is fixed at 512 (9-bit address).
REQ-002 clk  input  1  system clock (40 MHz).
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 trig1, trig2  input  1 each  analog-front-end trigger comparators, asynchronous to clk.
REQ-005 trig_src  input  1  0 selects trig1, 1 selects trig2.
REQ-006 trig_edge  input  1  1 = rising edge, 0 = falling edge.
REQ-007 trig_pos  input  9  number of post-trigger samples to store (0..511).
REQ-008 dec  input  4  decimation exponent; store one sample every 2^dec sample slots.
REQ-009 arm  input  1  single-clk pulse that starts a capture.
REQ-010 dump_start  input  1  single-clk pulse that starts readout.
REQ-011 dump_stall  input  1  consumer back-pressure during readout.
REQ-012 adc_clk  output  1  ADC clock, clk/2.
REQ-013 rclk  output  1  RAM clock, inverse of adc_clk.
REQ-014 en, we  output  1 each  RAM enable and write enable, shared by all three channel RAMs.
REQ-015 addr  output  9  RAM address.
REQ-016 trig_addr  output  9  address holding the trigger-slot sample.
REQ-017 busy, capture_done  output  1 each  status flags.
REQ-018 smp_vld  output  1  readout data-valid strobe; smp_idx  output  9  sample index, 0 = oldest.

Function
REQ-019 Phase bit ph SHALL toggle every clk; adc_clk = ph; rclk = ~ph; a sample slot is every clk in which ph = 1.
REQ-020 Decimation counter SHALL be 15 bits wide and advance once per sample slot; a write slot is a sample slot in which its low dec bits are all zero; the counter SHALL clear on arm.
REQ-021 Triggers SHALL pass through a two-flop synchronizer; an edge flag SHALL set on the selected edge of the selected source and be consumed at the next write slot.
REQ-022 States SHALL be IDLE, PRE, ARMED, POST, DONE, and DUMP.
REQ-023 IDLE: en = we = 0; arm moves to PRE with write pointer wp = 0 and pre-count = 0.
REQ-024 PRE/ARMED/POST: each write slot drives en = we = 1 and addr = wp, then wp increments modulo 512; outside write slots en = we = 0.
REQ-025 PRE SHALL count writes; after 511 - trig_pos writes it SHALL go to ARMED; edge flags SHALL be cleared and ignored in PRE.
REQ-026 ARMED: writes continue circularly; the first write slot with the edge flag set SHALL latch trig_addr = wp, write that sample, and go to POST.
REQ-027 POST: after trig_pos further writes, go to DONE; trig_pos = 0 goes to DONE directly after the trigger-slot write.
REQ-028 DONE: capture_done = 1; no writes; the oldest sample is at wp (trig_addr + trig_pos + 1, mod 512).
REQ-029 DONE: arm starts a new capture (to PRE); dump_start goes to DUMP with i = 0.
REQ-030 DUMP: at each sample slot with dump_stall = 0, drive en = 1, we = 0, addr = (wp + i) mod 512, then increment i.
REQ-031 smp_vld SHALL pulse for one clk at the next sample slot, with smp_idx = that i.
REQ-032 After i = 511 is presented and its smp_vld is issued, DUMP SHALL return to DONE.
REQ-033 dump_stall SHALL freeze i and addr and suppress new reads; a smp_vld already owed SHALL still issue.
REQ-034 arm outside IDLE/DONE and dump_start outside DONE SHALL be ignored; arm and dump_start together in DONE: arm wins.
REQ-035 busy = 1 in PRE, ARMED, POST, and DUMP.

Reset
REQ-036 rst_n low SHALL force IDLE immediately and clear ph, wp, i, the counters, the synchronizers, and the edge flag.
REQ-037 Reset values: adc_clk = 0, rclk = 1, en = 0, we = 0, addr = 0, trig_addr = 0, busy = 0, capture_done = 0, smp_vld = 0, smp_idx = 0.
REQ-038 Reset asserted mid-capture or mid-dump SHALL abort with no further RAM access.

Verification
REQ-039 dec = 0, trig_pos = 100, arm, rising trig1 after 600 slots -> exactly 411 PRE writes, trig_addr = wp at trigger, 100 post writes, capture_done = 1.
REQ-040 trig_pos = 0 and trig_pos = 511 -> 0 post writes / 0 pre writes respectively, then DONE.
REQ-041 Trigger edge during PRE -> ignored; the next edge in ARMED is taken.
REQ-042 dec = 3 -> we pulses exactly every 8 sample slots (16 clk).
REQ-043 Dump with dump_stall held 5 clk mid-stream -> 512 smp_vld pulses, smp_idx 0..511 with no gaps or repeats, first addr = oldest, wraps past 511.
REQ-044 rst_n pulsed low in POST and in DUMP -> all outputs at their REQ-037 reset values that cycle; a fresh arm then operates normally.
